// File: rtl/q8_8_alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational Q8.8 ALU among N_REQ requesters.
// Optional build macro Q8_8_ARB_TMR_EN triplicates the control state with majority voting.
module q8_8_alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [2*N_REQ-1:0]    req_op,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  output logic [1:0]            alu_op,
  input  logic [15:0]           alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy
`ifdef Q8_8_ARB_TMR_EN
  ,
  output logic                  tmr_mismatch
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [ID_W-1:0] LG_RST  = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_REQ_W = (ID_W + 1)'(N_REQ);

  state_e          state, state_d;
  logic [ID_W-1:0] last_grant, last_grant_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            cap_en;
  logic            rsp_cap;

  logic [15:0]     a_q, b_q;
  logic [1:0]      op_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_data_q;
  logic            rsp_valid_q;
  logic            busy_q;

  // Control state storage: single copy, or three voted copies that are scrubbed every cycle.
`ifdef Q8_8_ARB_TMR_EN
  state_e          state0_q, state1_q, state2_q;
  logic [ID_W-1:0] last_grant0_q, last_grant1_q, last_grant2_q;
  logic            copies_differ;
  logic            tmr_mismatch_q;

  assign state      = state_e'((state0_q & state1_q) | (state0_q & state2_q) | (state1_q & state2_q));
  assign last_grant = (last_grant0_q & last_grant1_q) | (last_grant0_q & last_grant2_q)
                    | (last_grant1_q & last_grant2_q);

  assign copies_differ = (state0_q != state1_q) || (state0_q != state2_q)
                      || (last_grant0_q != last_grant1_q) || (last_grant0_q != last_grant2_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state0_q       <= IDLE;
      state1_q       <= IDLE;
      state2_q       <= IDLE;
      last_grant0_q  <= LG_RST;
      last_grant1_q  <= LG_RST;
      last_grant2_q  <= LG_RST;
      tmr_mismatch_q <= 1'b0;
    end else begin
      state0_q       <= state_d;
      state1_q       <= state_d;
      state2_q       <= state_d;
      last_grant0_q  <= last_grant_d;
      last_grant1_q  <= last_grant_d;
      last_grant2_q  <= last_grant_d;
      tmr_mismatch_q <= copies_differ;
    end
  end

  assign tmr_mismatch = tmr_mismatch_q;
`else
  state_e          state_q;
  logic [ID_W-1:0] last_grant_q;

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LG_RST;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign state      = state_q;
  assign last_grant = last_grant_q;
`endif

  // Rotating-priority search starting just after the previous winner.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, last_grant} + (ID_W + 1)'(k);
      if (sum >= N_REQ_W) sum = sum - N_REQ_W;
      idx = sum[ID_W-1:0];
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // NOTE: every signal gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d      = state;
    last_grant_d = last_grant;
    req_ready    = '0;
    cap_en       = 1'b0;
    rsp_cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          cap_en               = 1'b1;
          last_grant_d         = grant_idx;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        rsp_cap = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because cleared operands and response are visible at the ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= (state_d == RESP);
      busy_q      <= (state_d != IDLE);
      if (cap_en) begin
        a_q  <= req_a[{grant_idx, 4'b0000} +: 16];
        b_q  <= req_b[{grant_idx, 4'b0000} +: 16];
        op_q <= req_op[{grant_idx, 1'b0} +: 2];
        id_q <= grant_idx;
      end
      if (rsp_cap) begin
        rsp_data_q <= alu_result;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_q8_8_alu_arbiter.sv
// Self-checking bench for q8_8_alu_arbiter: vector table, hand-written corner sequences and
// randomized transactions checked against a transaction-level round-robin model.
module tb_q8_8_alu_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a, req_b;
  logic [2*N-1:0]  req_op;
  logic [15:0]   alu_a, alu_b, alu_result;
  logic [1:0]    alu_op;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          busy;
`ifdef Q8_8_ARB_TMR_EN
  logic          tmr_mismatch;
`endif

  logic [15:0] a_v [N];
  logic [15:0] b_v [N];
  logic [1:0]  op_v[N];

  int n_pass  = 0;
  int n_total = 0;
  int lg;  // model: last granted requester

  q8_8_alu_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef Q8_8_ARB_TMR_EN
    , .tmr_mismatch(tmr_mismatch)
`endif
  );

  always #5 clk = ~clk;

  // Saturating Q8.8 ALU model shared by the attached ALU and the expected-value computation.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = (sa * sb) >>> 8;
      default: return 16'h0000;
    endcase
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  function automatic int next_grant(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always_comb alu_result = alu_fn(alu_a, alu_b, alu_op);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = a_v[i];
      req_b[16*i +: 16] = b_v[i];
      req_op[2*i +: 2]  = op_v[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lg = N - 1;
  endtask

  task automatic randomize_operands();
    for (int i = 0; i < N; i++) begin
      a_v[i]  = 16'($urandom);
      b_v[i]  = 16'($urandom);
      op_v[i] = 2'($urandom_range(0, 3));
    end
  endtask

  // One complete transaction; returns at a negedge with the DUT back in IDLE.
  task automatic run_txn(input logic [N-1:0] mask, input int exp_id, input logic [15:0] exp_data,
                         input int delay);
    logic [15:0] ea, eb;
    logic [1:0]  eo;
    ea = a_v[exp_id];
    eb = b_v[exp_id];
    eo = op_v[exp_id];
    @(posedge clk);
    #1 req_valid = mask;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("accept_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
    check("accept_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_rsp_valid", 32'(rsp_valid), 32'd0);
    check("issue_alu_a", 32'(alu_a), 32'(ea));
    check("issue_alu_b", 32'(alu_b), 32'(eb));
    check("issue_alu_op", 32'(alu_op), 32'(eo));
    @(negedge clk);
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_id", 32'(rsp_id), 32'(exp_id));
    check("resp_data", 32'(rsp_data), 32'(exp_data));
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'(exp_id));
      check("bp_data", 32'(rsp_data), 32'(exp_data));
      check("bp_alu_a", 32'(alu_a), 32'(ea));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("idle_alu_a_hold", 32'(alu_a), 32'(ea));
  endtask

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] exp;
    int          delay;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g_id [$];
    int g_cyc[$];
    int r_id [$];
    int g, exp_g;
    logic [N-1:0] mask;

    vecs[0] = '{id: 0, a: 16'h0100, b: 16'h0080, op: 2'd0, exp: 16'h0180, delay: 0};
    vecs[1] = '{id: 2, a: 16'h0180, b: 16'h0200, op: 2'd2, exp: 16'h0300, delay: 1};
    vecs[2] = '{id: 1, a: 16'h0100, b: 16'h0300, op: 2'd1, exp: 16'hFE00, delay: 0};
    vecs[3] = '{id: 3, a: 16'h1234, b: 16'h5678, op: 2'd3, exp: 16'h0000, delay: 2};
    vecs[4] = '{id: 0, a: 16'hFF00, b: 16'h0280, op: 2'd2, exp: 16'hFD80, delay: 0};
    vecs[5] = '{id: 1, a: 16'hFF80, b: 16'h0040, op: 2'd0, exp: 16'hFFC0, delay: 5};
    vecs[6] = '{id: 2, a: 16'h7F00, b: 16'h7F00, op: 2'd0, exp: 16'h7FFF, delay: 0};

    randomize_operands();
    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);

    // Vector table: single requester per row; other slices hold random noise.
    for (int v = 0; v < 7; v++) begin
      randomize_operands();
      a_v[vecs[v].id]  = vecs[v].a;
      b_v[vecs[v].id]  = vecs[v].b;
      op_v[vecs[v].id] = vecs[v].op;
      run_txn(4'(1 << vecs[v].id), vecs[v].id, vecs[v].exp, vecs[v].delay);
      lg = vecs[v].id;
    end

    // Contention: all requesters valid, consumer always ready.
    do_reset();
    randomize_operands();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 21; cyc++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) g_id.push_back(i);
        g_cyc.push_back(cyc);
      end
      if (rsp_valid) begin
        r_id.push_back(int'(rsp_id));
        check("cont_data", 32'(rsp_data), 32'(alu_fn(a_v[rsp_id], b_v[rsp_id], op_v[rsp_id])));
      end
`ifdef Q8_8_ARB_TMR_EN
      if (cyc == 4) begin
        force dut.last_grant1_q = ~dut.last_grant0_q;
        #1 release dut.last_grant1_q;
      end
      if (cyc == 5) begin
        check("tmr_pulse", 32'(tmr_mismatch), 32'd1);
        check("tmr_scrub", 32'(dut.last_grant1_q), 32'(dut.last_grant0_q));
      end
      if (cyc == 6) check("tmr_pulse_end", 32'(tmr_mismatch), 32'd0);
`endif
    end
    req_valid = '0;
    check("cont_grant_count", 32'(g_id.size() >= 6), 32'd1);
    exp_g = N - 1;
    for (int k = 0; k < g_id.size(); k++) begin
      exp_g = next_grant(exp_g, 4'hF);
      check("cont_order", 32'(g_id[k]), 32'(exp_g));
      if (k > 0) check("cont_interval", 32'(g_cyc[k] - g_cyc[k-1]), 32'd3);
    end
    for (int k = 0; k < r_id.size() && k < g_id.size(); k++)
      check("cont_rsp_id", 32'(r_id[k]), 32'(g_id[k]));
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure with all others waiting: no accept until the handshake, then next in turn.
    do_reset();
    randomize_operands();
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(negedge clk);
    check("bpq_accept", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1 req_valid = 4'b1111;
    @(negedge clk);
    check("bpq_issue_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("bpq_valid", 32'(rsp_valid), 32'd1);
      check("bpq_ready0", 32'(req_ready), 32'd0);
      check("bpq_id", 32'(rsp_id), 32'd1);
      check("bpq_data", 32'(rsp_data), 32'(alu_fn(a_v[1], b_v[1], op_v[1])));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    req_valid = 4'b0100;
    @(negedge clk);
    check("bpq_resume", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(negedge clk);
    check("bpq_next_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset asserted while a response is pending.
    do_reset();
    randomize_operands();
    @(posedge clk);
    #1 req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (2) @(negedge clk);
    check("mid_resp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    lg = N - 1;
    @(negedge clk);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(rsp_data), 32'd0);
    run_txn(4'b1000, 3, alu_fn(a_v[3], b_v[3], op_v[3]), 0);
    do_reset();
    run_txn(4'b0001, 0, alu_fn(a_v[0], b_v[0], op_v[0]), 1);
    lg = 0;

    // Randomized transactions against the round-robin model.
    for (int t = 0; t < 40; t++) begin
      randomize_operands();
      mask = 4'($urandom_range(1, 15));
      g = next_grant(lg, mask);
      run_txn(mask, g, alu_fn(a_v[g], b_v[g], op_v[g]), $urandom_range(0, 3));
      lg = g;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/q8_8_alu_arbiter.md
Name: q8_8_alu_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational Q8.8 fixed-point ALU (add/sub/mul) among N_REQ neuron-update requesters in the SNN core.
- Captures one requester's operands and drives the shared ALU from registers.
- Registers the ALU result and returns it through a valid/ready response channel tagged with the requester ID.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_a  input  16*N_REQ  operand A, Q8.8 signed; slice i belongs to requester i.
- req_b  input  16*N_REQ  operand B, Q8.8 signed; slice i belongs to requester i.
- req_op  input  2*N_REQ  opcode; 00 add, 01 sub, 10 mul, 11 reserved.
- alu_a  output  16  operand A to shared ALU.
- alu_b  output  16  operand B to shared ALU.
- alu_op  output  2  opcode to shared ALU.
- alu_result  input  16  combinational ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns rsp_data.
- rsp_data  output  16  registered ALU result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: synchronous, active-low, on rising edge with rst_n=0.
  - State goes to IDLE; last_grant = N_REQ-1, so requester 0 has first priority.
  - Operand, op, rsp_id and rsp_data registers all clear to 0; rsp_valid=0; req_ready=0; busy=0.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - Grant g is the first index with req_valid=1, searching (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - On that edge: capture req_a[g], req_b[g], req_op[g] and g into registers; set last_grant=g; go to ISSUE.
  - No valid requests: stay in IDLE, req_ready all 0.
- ISSUE (1 cycle):
  - alu_a, alu_b and alu_op are driven from the captured registers; they are stable for the whole transaction and hold their last values while IDLE.
  - At the end of the cycle, rsp_data <= alu_result and rsp_id <= captured g; go to RESP.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id hold stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: go to IDLE; rsp_valid drops the next cycle.
  - req_ready is 0 throughout ISSUE and RESP.
- Timing:
  - Latency: accept at cycle T, rsp_valid at T+2.
  - Minimum issue interval is 3 cycles with rsp_ready tied high.
- Arithmetic:
  - Operands and result pass through unmodified; saturation is owned by the ALU.
  - Op 11 is forwarded as-is; the ALU returns 0 and rsp_data=0.
- Fairness: a requester holding req_valid high is granted within N_REQ transactions.
- A requester dropping req_valid before its grant is simply skipped; no state is kept for it.
- Reset asserted mid-transaction (ISSUE or RESP): the transaction is discarded with no response, and the state returns to the reset values.
- rsp_ready high in IDLE or ISSUE has no effect.

Optional Feature:
- Macro: Q8_8_ARB_TMR_EN.
- Defined:
  - The FSM state and last_grant registers are triplicated; each copy updates from the same next-state logic.
  - Control uses bitwise 2-of-3 majority of the three copies; every copy is rewritten with the voted next value each cycle, which scrubs single upsets.
  - Extra output tmr_mismatch (1 bit, reset 0) goes high for one cycle whenever the copies disagree.
- Undefined: single copies of state and last_grant; no tmr_mismatch port.
- Functional behaviour is otherwise identical in both builds.

Test Plan:
- Single add: req 0, a=0x0100, b=0x0080, op=00 → req_ready[0] at T; rsp_valid at T+2 with rsp_data=0x0180, rsp_id=0.
- Mul through requester 2 (ALU model attached): a=0x0180 (1.5), b=0x0200 (2.0), op=10 → rsp_data=0x0300, rsp_id=2.
- Contention: all four req_valid held high, rsp_ready=1 → grant order 0,1,2,3,0,1; each accept 3 cycles apart; no requester skipped.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_data and rsp_id stable; req_ready stays 0; accept resumes in the cycle after the handshake.
- Reset mid-RESP: rst_n=0 for 1 cycle → next cycle rsp_valid=0, busy=0; a following request from req 3 alone is granted. Also check that a request from req 0 alone after reset is granted first.
- Q8_8_ARB_TMR_EN: force one copy of last_grant to a wrong value during contention → grant order unchanged; tmr_mismatch pulses 1 cycle; copies agree on the next cycle.
